reg_bank_sp_shadow: RTL and testbench
=====================================

REG_BANK_SP_SHADOW -- requirements
Module: reg_bank_sp_shadow

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per register.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning number of registers in the bank (1..256).
REQ-003 SHALL have parameter ADDR_WIDTH, default 2, meaning address bus width; it shall satisfy 2^ADDR_WIDTH >= NUM_REGS.
REQ-004 SHALL have parameter DEFAULT_VALUES, default all zeros, NUM_REGS*DATA_WIDTH bits, meaning the reset value of register k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-005 SHALL have parameter SHADOW_MASK, default all ones, NUM_REGS bits, meaning bit k=1 makes register k shadowed and bit k=0 makes it direct.
REQ-006 SHALL have port I_clk, input, 1 bit, meaning the master clock; it is the only clock.
REQ-007 SHALL have port I_reset, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-008 SHALL have port I_enable, input, 1 bit, meaning the enable for register access.
REQ-009 SHALL have port I_wen, input, 1 bit, meaning the write enable, qualified by I_enable.
REQ-010 SHALL have port I_addr, input, ADDR_WIDTH bits, meaning the register address.
REQ-011 SHALL have port I_din, input, DATA_WIDTH bits, meaning the write data.
REQ-012 SHALL have port I_transfer, input, 1 bit, meaning the shadow-to-active transfer request.
REQ-013 SHALL have port O_dout, output, DATA_WIDTH bits, meaning the registered read data.
REQ-014 SHALL have port O_rvalid, output, 1 bit, meaning O_dout holds read data for this cycle.
REQ-015 SHALL have port O_active, output, NUM_REGS*DATA_WIDTH bits, meaning the packed active values that drive the datapath.
REQ-016 SHALL have port O_pending, output, 1 bit, meaning at least one shadow value differs in origin from its active value (written since the last transfer).
REQ-017 SHALL have port O_xfer_done, output, 1 bit, meaning a one-cycle pulse after a transfer completes.

Function
REQ-018 Each register k SHALL hold two state values: a shadow value and an active value; a direct register (SHADOW_MASK[k]=0) SHALL keep the two values identical at all times.
REQ-019 A write occurs when I_enable=1, I_wen=1 and I_addr<NUM_REGS; the write SHALL update the shadow value at the next rising edge of I_clk.
REQ-020 For a direct register, the same write SHALL also update the active value at that edge; for a shadowed register, the write SHALL set O_pending=1.
REQ-021 A write with I_addr>=NUM_REGS SHALL be ignored: no state changes and O_pending is unaffected.
REQ-022 A read occurs when I_enable=1 and I_wen=0; at the next edge O_rvalid SHALL be 1 and O_dout SHALL hold the shadow value of I_addr, or 0 if I_addr>=NUM_REGS; the read latency is 1 cycle.
REQ-023 When no read occurs, O_rvalid SHALL be 0 at the next edge and O_dout SHALL hold its last value.
REQ-024 A transfer request is I_transfer=1 sampled at an edge; the bank SHALL copy every shadowed register's shadow value into its active value at the following edge (state XFER), then assert O_xfer_done for exactly one cycle and clear O_pending.
REQ-025 The transfer FSM SHALL have the states IDLE and XFER; IDLE->XFER occurs on I_transfer=1; XFER->IDLE occurs unconditionally after one cycle; I_transfer is ignored while in XFER.
REQ-026 On a write to a shadowed register in the same cycle as the XFER copy, the copy SHALL use the newly written value (write forwarded), and O_pending SHALL be 0 afterwards.
REQ-027 On a write to a shadowed register in the cycle that I_transfer is sampled in IDLE, the write SHALL land in the shadow value and be included in the following XFER copy.
REQ-028 A transfer with O_pending=0 SHALL still run and pulse O_xfer_done; the active values do not change.
REQ-029 O_active SHALL change only at the edges given in REQ-020 and REQ-024 and shall never glitch between edges.

Reset
REQ-030 While I_reset=1 at an edge, every shadow and active value SHALL load DEFAULT_VALUES; O_dout=0, O_rvalid=0, O_pending=0, O_xfer_done=0 and the FSM returns to IDLE.
REQ-031 Reset SHALL take priority over writes, reads and transfers, including a reset asserted during XFER, which aborts the copy.

Verification
REQ-032 Reset with NUM_REGS=4, DEFAULT_VALUES=0x44332211 -> O_active=0x44332211, O_pending=0, O_rvalid=0.
REQ-033 Write 0xA5 to addr 1 (shadowed) -> read addr 1 returns 0xA5 with O_rvalid one cycle later; O_active[15:8] stays 0x22; O_pending=1.
REQ-034 After REQ-033, pulse I_transfer -> O_active[15:8]=0xA5 two edges later; O_xfer_done pulses once; O_pending=0.
REQ-035 SHADOW_MASK=4'b1011, write 0x5A to addr 2 -> O_active[23:16]=0x5A at the next edge; O_pending stays 0.
REQ-036 Write 0x77 to addr 0 in the XFER cycle -> O_active[7:0]=0x77 and O_pending=0; write to addr 5 with ADDR_WIDTH=3 -> no change; read addr 5 -> 0.
REQ-037 Assert I_reset in the XFER cycle -> no O_xfer_done pulse; all values return to DEFAULT_VALUES.

Source files
------------

// File: rtl/reg_bank_sp_shadow.sv
// Register bank with per-register shadow/active pairs. Software writes land in
// the shadow copy; shadowed registers reach the datapath (O_active) only when a
// transfer is requested, while direct registers update both copies at once.
module reg_bank_sp_shadow #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] DEFAULT_VALUES = '0,
    parameter logic [NUM_REGS-1:0]            SHADOW_MASK    = '1
) (
    input  logic                           I_clk,
    input  logic                           I_reset,
    input  logic                           I_enable,
    input  logic                           I_wen,
    input  logic [ADDR_WIDTH-1:0]          I_addr,
    input  logic [DATA_WIDTH-1:0]          I_din,
    input  logic                           I_transfer,
    output logic [DATA_WIDTH-1:0]          O_dout,
    output logic                           O_rvalid,
    output logic [NUM_REGS*DATA_WIDTH-1:0] O_active,
    output logic                           O_pending,
    output logic                           O_xfer_done
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StXfer = 1'b1;

    logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] active_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] active_d [NUM_REGS];

    logic [0:0]            state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  xfer_done_q, xfer_done_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rvalid_q, rvalid_d;

    logic [31:0]           addr_ext;
    logic                  addr_ok;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;

    assign addr_ext = 32'(I_addr);
    assign addr_ok  = addr_ext < 32'(NUM_REGS);
    assign wr_en    = I_enable && I_wen && addr_ok;
    assign rd_en    = I_enable && !I_wen;

    // Read mux over the shadow copies; out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_ext == 32'(k)) begin
                rd_data = shadow_q[k];
            end
        end
    end

    // Next-state of the register pairs. The copy in XFER uses shadow_d so that a
    // write in that same cycle is forwarded into the active value.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            shadow_d[k] = shadow_q[k];
            active_d[k] = active_q[k];
            if (wr_en && (addr_ext == 32'(k))) begin
                shadow_d[k] = I_din;
            end
            if (!SHADOW_MASK[k]) begin
                active_d[k] = shadow_d[k];
            end else if (state_q == StXfer) begin
                active_d[k] = shadow_d[k];
            end
        end
    end

    // Pending flag, transfer FSM and registered read port.
    always_comb begin
        pending_d   = pending_q;
        state_d     = state_q;
        xfer_done_d = 1'b0;
        dout_d      = dout_q;
        rvalid_d    = 1'b0;

        if (state_q == StXfer) begin
            // Any write this cycle is already folded into the copy.
            pending_d   = 1'b0;
            xfer_done_d = 1'b1;
            state_d     = StIdle;
        end else begin
            if (wr_en) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if ((addr_ext == 32'(k)) && SHADOW_MASK[k]) begin
                        pending_d = 1'b1;
                    end
                end
            end
            if (I_transfer) begin
                state_d = StXfer;
            end
        end

        if (rd_en) begin
            dout_d   = rd_data;
            rvalid_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow_q[k] <= DEFAULT_VALUES[k*DATA_WIDTH +: DATA_WIDTH];
                active_q[k] <= DEFAULT_VALUES[k*DATA_WIDTH +: DATA_WIDTH];
            end
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            xfer_done_q <= 1'b0;
            dout_q      <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            state_q     <= state_d;
            pending_q   <= pending_d;
            xfer_done_q <= xfer_done_d;
            dout_q      <= dout_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Pack active values straight from flops so O_active cannot glitch.
    always_comb begin
        O_active = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            O_active[k*DATA_WIDTH +: DATA_WIDTH] = active_q[k];
        end
    end

    assign O_dout      = dout_q;
    assign O_rvalid    = rvalid_q;
    assign O_pending   = pending_q;
    assign O_xfer_done = xfer_done_q;

endmodule

// File: tb/tb_reg_bank_sp_shadow.sv
// Bench for reg_bank_sp_shadow: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_reg_bank_sp_shadow;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int AW = 3;
    localparam logic [NR*DW-1:0] DEFS = 32'h44332211;
    localparam logic [NR-1:0]    MASK = 4'b1011;

    logic          clk;
    logic          I_reset;
    logic          I_enable;
    logic          I_wen;
    logic [AW-1:0] I_addr;
    logic [DW-1:0] I_din;
    logic          I_transfer;
    logic [DW-1:0] O_dout;
    logic          O_rvalid;
    logic [NR*DW-1:0] O_active;
    logic          O_pending;
    logic          O_xfer_done;

    int vectors;
    int miscompares;

    // Behavioural model state.
    logic [DW-1:0] m_sh [NR];
    logic [DW-1:0] m_ac [NR];
    logic          m_pending;
    logic          m_in_xfer;
    logic [DW-1:0] m_dout;
    logic          m_rvalid;
    logic          m_done;

    reg_bank_sp_shadow #(
        .DATA_WIDTH    (DW),
        .NUM_REGS      (NR),
        .ADDR_WIDTH    (AW),
        .DEFAULT_VALUES(DEFS),
        .SHADOW_MASK   (MASK)
    ) dut (
        .I_clk      (clk),
        .I_reset    (I_reset),
        .I_enable   (I_enable),
        .I_wen      (I_wen),
        .I_addr     (I_addr),
        .I_din      (I_din),
        .I_transfer (I_transfer),
        .O_dout     (O_dout),
        .O_rvalid   (O_rvalid),
        .O_active   (O_active),
        .O_pending  (O_pending),
        .O_xfer_done(O_xfer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_active();
        logic [NR*DW-1:0] v;
        for (int k = 0; k < NR; k++) v[k*DW +: DW] = m_ac[k];
        return v;
    endfunction

    // One rising edge of the bank, described by its rules rather than its circuit.
    task automatic model_edge();
        int a;
        a = int'(I_addr);
        if (I_reset) begin
            for (int k = 0; k < NR; k++) begin
                m_sh[k] = DEFS[k*DW +: DW];
                m_ac[k] = DEFS[k*DW +: DW];
            end
            m_pending = 1'b0;
            m_in_xfer = 1'b0;
            m_dout    = '0;
            m_rvalid  = 1'b0;
            m_done    = 1'b0;
        end else begin
            // Read sees the shadow value before this edge's write.
            if (I_enable && !I_wen) begin
                m_dout   = (a < NR) ? m_sh[a] : '0;
                m_rvalid = 1'b1;
            end else begin
                m_rvalid = 1'b0;
            end
            if (I_enable && I_wen && a < NR) begin
                m_sh[a] = I_din;
                if (!MASK[a]) m_ac[a] = I_din;
                else if (!m_in_xfer) m_pending = 1'b1;
            end
            m_done = m_in_xfer;
            if (m_in_xfer) begin
                for (int k = 0; k < NR; k++) if (MASK[k]) m_ac[k] = m_sh[k];
                m_pending = 1'b0;
                m_in_xfer = 1'b0;
            end else begin
                m_in_xfer = I_transfer;
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic wen,
                        input logic [AW-1:0] addr, input logic [DW-1:0] din,
                        input logic xfer);
        I_reset    = rst;
        I_enable   = en;
        I_wen      = wen;
        I_addr     = addr;
        I_din      = din;
        I_transfer = xfer;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("model_active",  64'(O_active),    64'(model_active()));
        check_eq("model_pending", 64'(O_pending),   64'(m_pending));
        check_eq("model_rvalid",  64'(O_rvalid),    64'(m_rvalid));
        check_eq("model_dout",    64'(O_dout),      64'(m_dout));
        check_eq("model_xfer_done", 64'(O_xfer_done), 64'(m_done));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < NR; k++) begin
            m_sh[k] = '0;
            m_ac[k] = '0;
        end
        m_pending = 1'b0;
        m_in_xfer = 1'b0;
        m_dout    = '0;
        m_rvalid  = 1'b0;
        m_done    = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check_eq("rst_active",  64'(O_active),  64'h44332211);
        check_eq("rst_pending", 64'(O_pending), 64'h0);
        check_eq("rst_rvalid",  64'(O_rvalid),  64'h0);
        check_eq("rst_done",    64'(O_xfer_done), 64'h0);

        // Shadowed write stays hidden until transfer.
        step(1'b0, 1'b1, 1'b1, 3'd1, 8'hA5, 1'b0);
        check_eq("wr1_active",  64'(O_active),  64'h44332211);
        check_eq("wr1_pending", 64'(O_pending), 64'h1);
        step(1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        check_eq("rd1_dout",   64'(O_dout),   64'hA5);
        check_eq("rd1_rvalid", 64'(O_rvalid), 64'h1);
        idle();
        check_eq("noread_rvalid", 64'(O_rvalid), 64'h0);
        check_eq("noread_hold",   64'(O_dout),   64'hA5);

        // Transfer: sampled, then copy on the following edge.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        check_eq("xfer_e0_byte1", 64'(O_active[15:8]), 64'h22);
        check_eq("xfer_e0_done",  64'(O_xfer_done),    64'h0);
        idle();
        check_eq("xfer_e1_byte1",   64'(O_active[15:8]), 64'hA5);
        check_eq("xfer_e1_done",    64'(O_xfer_done),    64'h1);
        check_eq("xfer_e1_pending", 64'(O_pending),      64'h0);
        idle();
        check_eq("xfer_done_once", 64'(O_xfer_done), 64'h0);

        // Direct register updates active immediately.
        step(1'b0, 1'b1, 1'b1, 3'd2, 8'h5A, 1'b0);
        check_eq("direct_byte2",   64'(O_active[23:16]), 64'h5A);
        check_eq("direct_pending", 64'(O_pending),       64'h0);

        // Write in the XFER cycle is forwarded into the copy.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 3'd0, 8'h77, 1'b0);
        check_eq("fwd_active",  64'(O_active),    64'h445AA577);
        check_eq("fwd_pending", 64'(O_pending),   64'h0);
        check_eq("fwd_done",    64'(O_xfer_done), 64'h1);

        // Out-of-range write and read.
        step(1'b0, 1'b1, 1'b1, 3'd5, 8'hFF, 1'b0);
        check_eq("oor_wr_active",  64'(O_active),  64'h445AA577);
        check_eq("oor_wr_pending", 64'(O_pending), 64'h0);
        step(1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
        check_eq("oor_rd_dout",   64'(O_dout),   64'h0);
        check_eq("oor_rd_rvalid", 64'(O_rvalid), 64'h1);

        // Reset during XFER aborts the copy.
        step(1'b0, 1'b1, 1'b1, 3'd3, 8'h99, 1'b0);
        check_eq("pre_abort_pending", 64'(O_pending), 64'h1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check_eq("abort_active",  64'(O_active),    64'h44332211);
        check_eq("abort_done",    64'(O_xfer_done), 64'h0);
        check_eq("abort_pending", 64'(O_pending),   64'h0);
        idle();
        check_eq("abort_no_late_done", 64'(O_xfer_done), 64'h0);
        check_eq("abort_active_hold",  64'(O_active),    64'h44332211);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 7)),
                 DW'($urandom),
                 ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
